// File: rtl/param_seq_detector.sv
// param_seq_detector: run-time programmable serial pattern detector.
// Pattern, length and overlap mode load through pat_load; serial bits are
// qualified by bit_en. Produces a registered one-cycle hit pulse, a
// saturating hit counter, an armed flag and a cfg_err pulse on bad loads.
// Optional build macro: SEQ_DET_ERR_TOL_EN (tolerate up to ERR_TOL
// mismatching bits instead of requiring an exact match).
module param_seq_detector #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] RST_PAT = 16'h01D3,
    parameter int unsigned RST_LEN = 9,
    parameter bit          RST_OVL = 1'b1,
    parameter int unsigned ERR_TOL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_en,
    input  logic               bit_in,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_value,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               hit,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic               armed,
    output logic               cfg_err
);

`ifdef SEQ_DET_ERR_TOL_EN
    localparam int unsigned TolEn = 1;
`else
    localparam int unsigned TolEn = 0;
`endif
    // Effective tolerance: zero forces an exact match.
    localparam int unsigned Tol = ERR_TOL * TolEn;

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] shift_hist;
    logic [MAX_LEN-1:0] diff;
    logic [LEN_W-1:0]   shift_fill;
    logic               cfg_ok;
    logic               match;
    int unsigned        err_cnt;

    // Candidate history/fill after accepting bit_in, and the match test on it.
    always_comb begin
        len_mask   = '0;
        err_cnt    = 0;
        shift_hist = {history_q[MAX_LEN-2:0], bit_in};
        shift_fill = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        diff = (shift_hist ^ pat_q) & len_mask;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            err_cnt = err_cnt + {31'd0, diff[i]};
        end
        match  = (err_cnt <= Tol) && (shift_fill >= len_q);
        cfg_ok = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    end

    // Next-state: config load, bit acceptance, hit generation and counter.
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hit_d     = 1'b0;
        cfg_err_d = 1'b0;
        cnt_d     = cnt_q;

        if (pat_load && cfg_ok) begin
            // Valid load restarts matching; a coincident bit is dropped.
            pat_d     = pat_value;
            len_d     = pat_len;
            ovl_d     = overlap;
            history_d = '0;
            fill_d    = '0;
        end else begin
            cfg_err_d = pat_load;
            if (bit_en) begin
                history_d = shift_hist;
                fill_d    = shift_fill;
                if (match) begin
                    hit_d = 1'b1;
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                end
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        armed_d = (fill_d >= len_d);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
            pat_q     <= RST_PAT;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= RST_OVL;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign hit     = hit_q;
    assign hit_cnt = cnt_q;
    assign armed   = armed_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector (CNT_W=4 so saturation is reachable).
// Expected hit values are queued when a bit is driven and popped when the
// registered hit is sampled one cycle later.
module tb_param_seq_detector;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               bit_en = 1'b0;
    logic               bit_in = 1'b0;
    logic               pat_load = 1'b0;
    logic [MAX_LEN-1:0] pat_value = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b0;
    logic               cnt_clr = 1'b0;
    logic               hit;
    logic [CNT_W-1:0]   hit_cnt;
    logic               armed;
    logic               cfg_err;

    int   vectors = 0;
    int   miscompares = 0;
    logic exp_q[$];

    param_seq_detector #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_en   (bit_en),
        .bit_in   (bit_in),
        .pat_load (pat_load),
        .pat_value(pat_value),
        .pat_len  (pat_len),
        .overlap  (overlap),
        .cnt_clr  (cnt_clr),
        .hit      (hit),
        .hit_cnt  (hit_cnt),
        .armed    (armed),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_bit(input logic b, input logic e, input int gap, input logic clr);
        logic want;
        @(negedge clk);
        bit_en  = 1'b1;
        bit_in  = b;
        cnt_clr = clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bit_en  = 1'b0;
        cnt_clr = 1'b0;
        want = exp_q.pop_front();
        vectors++;
        if (hit !== want) begin
            miscompares++;
            $display("FAIL hit: got %b, want %b (t=%0t)", hit, want, $time);
        end
        for (int g = 0; g < gap; g++) begin
            idle_cycle();
            vectors++;
            if (hit !== 1'b0) begin
                miscompares++;
                $display("FAIL hit_idle: got %b, want 0 (t=%0t)", hit, $time);
            end
        end
    endtask

    // bits[n-1] is sent first; exp[i] is the hit expected for bits[i].
    task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] e,
                        input int gap);
        logic [31:0] bv;
        logic [31:0] ev;
        bv = bits;
        ev = e;
        for (int i = n - 1; i >= 0; i--) begin
            drive_bit(bv[i], ev[i], gap, 1'b0);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [4:0] l, input logic o,
                           input logic with_bit, input logic b, input logic exp_err);
        @(negedge clk);
        pat_load  = 1'b1;
        pat_value = v;
        pat_len   = l;
        overlap   = o;
        bit_en    = with_bit;
        bit_in    = b;
        @(posedge clk);
        #1;
        pat_load = 1'b0;
        bit_en   = 1'b0;
        vectors++;
        if (cfg_err !== exp_err) begin
            miscompares++;
            $display("FAIL cfg_err: got %b, want %b (t=%0t)", cfg_err, exp_err, $time);
        end
        vectors++;
        if (hit !== 1'b0) begin
            miscompares++;
            $display("FAIL hit_on_load: got %b, want 0 (t=%0t)", hit, $time);
        end
        idle_cycle();
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_width: got %b, want 0 (t=%0t)", cfg_err, $time);
        end
    endtask

    task automatic clear_cnt();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        vectors++;
        if (hit_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_clr: got %0d, want 0", hit_cnt);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({hit, armed, cfg_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 000", {hit, armed, cfg_err});
        end
        vectors++;
        if (hit_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d, want 0", hit_cnt);
        end
    endtask

    task automatic test_default_overlap();
        feed(32'b11101001, 8, 32'd0, 3);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL armed_8: got %b, want 0", armed);
        end
        feed(32'b1, 1, 32'b1, 3);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL armed_9: got %b, want 1", armed);
        end
        feed(32'b111010011, 9, 32'b1, 3);
        feed(32'b111010011, 9, 32'b1, 3);
        vectors++;
        if (hit_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL default_cnt: got %0d, want 3", hit_cnt);
        end
    endtask

    task automatic test_short_pattern();
        do_load(16'b11, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_cnt();
        feed(32'b1111, 4, 32'b0111, 0);
        vectors++;
        if (hit_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL ovl_cnt: got %0d, want 3", hit_cnt);
        end
        do_load(16'b11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_cnt();
        feed(32'b1111, 4, 32'b0101, 0);
        vectors++;
        if (hit_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL novl_cnt: got %0d, want 2", hit_cnt);
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        do_load(16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(32'b111010011, 9, 32'b1, 1);
        vectors++;
        if (hit_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL cfg_keep_cnt: got %0d, want 1", hit_cnt);
        end
        // Rejected load with a coincident bit: the bit starts the next pattern.
        do_load(16'h0000, 5'd17, 1'b0, 1'b1, 1'b1, 1'b1);
        feed(32'b11010011, 8, 32'b1, 0);
        vectors++;
        if (hit_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL cfg_bit_cnt: got %0d, want 2", hit_cnt);
        end
        // Accepted load with a coincident bit: the bit is discarded.
        do_load(16'b11, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL load_armed: got %b, want 0", armed);
        end
        vectors++;
        if (hit_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL load_cnt: got %0d, want 2", hit_cnt);
        end
        feed(32'b11, 2, 32'b01, 0);
    endtask

    task automatic test_saturate();
        do_load(16'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_cnt();
        for (int i = 0; i < 20; i++) begin
            drive_bit(1'b1, 1'b1, 0, 1'b0);
        end
        vectors++;
        if (hit_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_cnt: got %0d, want 15", hit_cnt);
        end
        drive_bit(1'b1, 1'b1, 0, 1'b1);
        vectors++;
        if (hit_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_beats_hit: got %0d, want 0", hit_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        feed(32'b11101, 5, 32'd0, 1);
        do_reset();
        vectors++;
        if ({armed, hit_cnt} !== 5'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b, want 00000", {armed, hit_cnt});
        end
        feed(32'b111010011, 9, 32'b1, 1);
    endtask

    task automatic test_err_tol();
        logic tol_hit;
`ifdef SEQ_DET_ERR_TOL_EN
        tol_hit = 1'b1;
`else
        tol_hit = 1'b0;
`endif
        do_reset();
        feed(32'b111010111, 9, {31'd0, tol_hit}, 0);
        do_reset();
        feed(32'b110010111, 9, 32'd0, 0);
    endtask

    initial begin
        test_reset();
        test_default_overlap();
        test_short_pattern();
        test_cfg_err();
        test_saturate();
        test_reset_midstream();
        test_err_tol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
